// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared types and constants for the memory_phase pipeline stage:
//            FSM state encoding and load/store size codes (funct3).
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Transaction FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Access size / sign codes carried in funct3
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unused size codes (011/110/111) behave as a full word access
  function automatic logic [2:0] norm_funct3(input logic [2:0] f3);
    logic [2:0] r;
    case (f3)
      F3_B, F3_H, F3_BU, F3_HU: r = f3;
      default:                  r = F3_W;
    endcase
    return r;
  endfunction

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_align
// Brief    : Purely combinational lane logic for memory_phase: alignment
//            check of an incoming access, store byte-enable / data lane
//            replication, and load byte/half extraction with extension.
//            All funct3 inputs are expected already normalised.
// Revision : 1.0 - initial release
// ============================================================================
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_chk_addr_lo,
  input  logic [2:0]  i_chk_funct3,
  output logic        o_misaligned,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_store_data,
  output logic [3:0]  o_mask,
  output logic [31:0] o_wdata,
  input  logic [31:0] i_load_word,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Word accesses need a 4-byte aligned address, halves a 2-byte one
  always_comb begin
    o_misaligned = 1'b0;
    case (i_chk_funct3)
      F3_W:        o_misaligned = (i_chk_addr_lo != 2'b00);
      F3_H, F3_HU: o_misaligned = i_chk_addr_lo[0];
      default:     o_misaligned = 1'b0;
    endcase
  end

  // Replicate store data across all lanes; the mask selects the real bytes
  always_comb begin
    o_mask  = 4'hF;
    o_wdata = i_store_data;
    case (i_funct3)
      F3_B, F3_BU: begin
        o_mask  = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_store_data[7:0]}};
      end
      F3_H, F3_HU: begin
        o_mask  = 4'b0011 << i_addr_lo;
        o_wdata = {2{i_store_data[15:0]}};
      end
      default: begin
        o_mask  = 4'hF;
        o_wdata = i_store_data;
      end
    endcase
  end

  // Pick the addressed byte/half out of the returned word and extend it
  always_comb begin
    w_byte = i_load_word[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_load_word[7:0];
      2'd1:    w_byte = i_load_word[15:8];
      2'd2:    w_byte = i_load_word[23:16];
      default: w_byte = i_load_word[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_load_word[31:16] : i_load_word[15:0];
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_data = {24'd0, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_data = {16'd0, w_half};
      default: o_load_data = i_load_word;
    endcase
  end

endmodule : mem_align
`default_nettype wire

// File: rtl/memory_phase.sv
`default_nettype none
// ============================================================================
// Module   : memory_phase
// Brief    : Pipeline stage after execute. Passes ALU results through with
//            one cycle of latency, or performs a load/store over a
//            req/gnt/rvalid handshake while stalling upstream, then emits a
//            registered write-back bundle. Accesses that stay in flight for
//            RESP_TIMEOUT cycles are aborted.
// Revision : 1.0 - initial release
// ============================================================================
module memory_phase
  import mem_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_stall,
  input  logic [31:0] i_result,
  input  logic [31:0] i_rs2_rdata,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_funct3,
  input  logic [4:0]  i_rd,
  input  logic        i_reg_write,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_mask,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_wb_valid,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_wb_rd,
  output logic        o_wb_reg_write,
  output logic        o_misaligned,
  output logic        o_timeout
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(RESP_TIMEOUT - 1);

  state_e           state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [31:0]      addr_q,       addr_d;
  logic [31:0]      sdata_q,      sdata_d;
  logic [2:0]       funct3_q,     funct3_d;
  logic [4:0]       rd_q,         rd_d;
  logic             reg_write_q,  reg_write_d;
  logic             we_q,         we_d;
  logic             wb_valid_q,   wb_valid_d;
  logic [31:0]      wb_data_q,    wb_data_d;
  logic [4:0]       wb_rd_q,      wb_rd_d;
  logic             wb_rw_q,      wb_rw_d;
  logic             misaligned_q, misaligned_d;
  logic             timeout_q,    timeout_d;

  logic [2:0]  w_f3n;
  logic        w_is_mem;
  logic        w_misaligned;
  logic        w_expire;
  logic        w_in_req;
  logic [3:0]  w_mask;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  assign w_f3n    = norm_funct3(i_funct3);
  assign w_is_mem = i_mem_read | i_mem_write;
  assign w_expire = (cnt_q == C_CNT_LAST);
  assign w_in_req = (state_q == REQ);

  mem_align u_align (
    .i_chk_addr_lo (i_result[1:0]),
    .i_chk_funct3  (w_f3n),
    .o_misaligned  (w_misaligned),
    .i_addr_lo     (addr_q[1:0]),
    .i_funct3      (funct3_q),
    .i_store_data  (sdata_q),
    .o_mask        (w_mask),
    .o_wdata       (w_wdata),
    .i_load_word   (i_dmem_rdata),
    .o_load_data   (w_load_data)
  );

  // Next-state, transaction latching and write-back bundle generation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    sdata_d      = sdata_q;
    funct3_d     = funct3_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    we_d         = we_q;
    wb_valid_d   = 1'b0;
    wb_data_d    = wb_data_q;
    wb_rd_d      = wb_rd_q;
    wb_rw_d      = wb_rw_q;
    misaligned_d = 1'b0;
    timeout_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_valid && !w_is_mem) begin
          wb_valid_d = 1'b1;
          wb_data_d  = i_result;
          wb_rd_d    = i_rd;
          wb_rw_d    = i_reg_write;
        end else if (i_valid) begin
          addr_d      = i_result;
          sdata_d     = i_rs2_rdata;
          funct3_d    = w_f3n;
          rd_d        = i_rd;
          reg_write_d = i_reg_write;
          // A store takes priority when both load and store are flagged
          we_d        = i_mem_write;
          if (w_misaligned) begin
            wb_valid_d   = 1'b1;
            misaligned_d = 1'b1;
            wb_data_d    = 32'd0;
            wb_rd_d      = i_rd;
            wb_rw_d      = 1'b0;
          end else begin
            state_d = REQ;
            cnt_d   = '0;
          end
        end
      end

      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_dmem_gnt && we_q) begin
          wb_valid_d = 1'b1;
          wb_data_d  = 32'd0;
          wb_rd_d    = rd_q;
          wb_rw_d    = 1'b0;
          state_d    = IDLE;
        end else if (w_expire) begin
          // A load grant on the last cycle still leaves the data outstanding
          wb_valid_d = 1'b1;
          timeout_d  = 1'b1;
          wb_data_d  = 32'd0;
          wb_rd_d    = rd_q;
          wb_rw_d    = 1'b0;
          state_d    = IDLE;
        end else if (i_dmem_gnt) begin
          state_d = RESP;
        end
      end

      RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_dmem_rvalid) begin
          wb_valid_d = 1'b1;
          wb_data_d  = w_load_data;
          wb_rd_d    = rd_q;
          wb_rw_d    = reg_write_q;
          state_d    = IDLE;
        end else if (w_expire) begin
          wb_valid_d = 1'b1;
          timeout_d  = 1'b1;
          wb_data_d  = 32'd0;
          wb_rd_d    = rd_q;
          wb_rw_d    = 1'b0;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any open transaction
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= 32'd0;
      sdata_q      <= 32'd0;
      funct3_q     <= 3'd0;
      rd_q         <= 5'd0;
      reg_write_q  <= 1'b0;
      we_q         <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_data_q    <= 32'd0;
      wb_rd_q      <= 5'd0;
      wb_rw_q      <= 1'b0;
      misaligned_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      sdata_q      <= sdata_d;
      funct3_q     <= funct3_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      we_q         <= we_d;
      wb_valid_q   <= wb_valid_d;
      wb_data_q    <= wb_data_d;
      wb_rd_q      <= wb_rd_d;
      wb_rw_q      <= wb_rw_d;
      misaligned_q <= misaligned_d;
      timeout_q    <= timeout_d;
    end
  end

  // Memory request is driven only in REQ so every field reads zero otherwise
  always_comb begin
    o_stall      = (state_q != IDLE);
    o_dmem_req   = w_in_req;
    o_dmem_we    = w_in_req & we_q;
    o_dmem_addr  = w_in_req ? {addr_q[31:2], 2'b00} : 32'd0;
    o_dmem_wdata = w_in_req ? w_wdata : 32'd0;
    o_dmem_mask  = w_in_req ? w_mask : 4'd0;
  end

  assign o_wb_valid     = wb_valid_q;
  assign o_wb_data      = wb_data_q;
  assign o_wb_rd        = wb_rd_q;
  assign o_wb_reg_write = wb_rw_q;
  assign o_misaligned   = misaligned_q;
  assign o_timeout      = timeout_q;

endmodule : memory_phase
`default_nettype wire
